hvac_controller: RTL and testbench
==================================

# hvac_controller

Closed-loop HVAC actuator stage that sits directly downstream of the thermostat front end. It consumes the captured room temperature, its capture strobe, the user set point and the raw flame input. It decides heating/cooling with a hysteresis band, minimum run/rest times, sensor-staleness detection and flame lockout, then drives registered relay enables and status bits toward the Arduino I/O and LEDs.

## Interface
Parameters:
- TICK_DIV, 50_000_000: CLOCK_50 cycles per 1 s tick; the bench overrides it to 10.
- HYST, 1: hysteresis in °C, legal range 0..9.
- MIN_ON_S, 60: minimum seconds in HEAT/COOL before a demand-driven stop.
- MIN_OFF_S, 120: seconds spent in REST before demand is re-evaluated.
- STALE_S, 10: seconds without a valid sample before temperature is declared stale.
- FAN_OVR_S, 30: fan overrun seconds; used only with the configuration macro.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- cur_temp  in  8  captured temperature, °C
- cur_valid  in  1  one-cycle capture strobe, synchronous to CLOCK_50
- set_temp  in  8  set point, 0..99
- flame_in  in  1  raw asynchronous flame input
- heat_on  out  1  heating relay enable
- cool_on  out  1  cooling relay enable
- fan_on  out  1  fan relay enable
- state_code  out  3  OFF=0, HEAT=1, COOL=2, REST=3, FLAME=4
- fault_stale  out  1  temperature stale
- fault_flame  out  1  flame lockout active

## Operation
- Sample handling: on cur_valid with cur_temp in 1..99, load temp_r and reset the stale counter. cur_valid with cur_temp of 0 or >99 is ignored and does not refresh freshness. temp_ok is 0 from reset until the first valid sample, and drops to 0 when STALE_S ticks pass with no valid sample.
- Comparisons are unsigned 9-bit, so there is no wrap.
  - heat_start: temp_r + HYST < set_temp
  - cool_start: temp_r > set_temp + HYST
  - heat_stop: temp_r >= set_temp
  - cool_stop: temp_r <= set_temp
  - heat_start and cool_start are mutually exclusive.
- State machine (priority top-down, evaluated every cycle):
  - From any state, flame_s=1 → FLAME.
  - OFF: temp_ok & heat_start → HEAT; temp_ok & cool_start → COOL.
  - HEAT/COOL: !temp_ok → REST immediately. The matching stop condition → REST, but only once sec_cnt >= MIN_ON_S.
  - REST: sec_cnt >= MIN_OFF_S → OFF.
  - FLAME: flame_s=0 for 5 consecutive ticks → REST.
- sec_cnt: 16-bit. Cleared on every state entry, +1 per tick, saturates at 0xFFFF. The flame-clear count restarts whenever flame_s=1.
- Outputs:
  - heat_on = (state==HEAT); cool_on = (state==COOL).
  - fault_flame = (state==FLAME); fault_stale = !temp_ok.
- set_temp changes mid-run take effect on the next cycle; no restart of sec_cnt.

## Timing
- Reset: state OFF; all outputs 0 (state_code 0). temp_r=0, temp_ok=0, sec_cnt=0, prescaler=0.
- Tick: a one-cycle pulse when the prescaler reaches TICK_DIV-1. The first tick comes TICK_DIV cycles after reset release.
- cur_valid at cycle N: temp_r updates at N+1 and outputs reflect any new state at N+2.
- flame_in rising: 2-flop synchronizer, then FSM, so all relays are 0 three cycles after the edge.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset mid-run drops every relay on the next edge. The MIN_OFF_S rest is not applied after reset.

## Configuration
- HVAC_FAN_OVERRUN_EN defined:
  - fan_on = 1 in HEAT/COOL.
  - fan_on also stays 1 in REST while sec_cnt < FAN_OVR_S after leaving HEAT/COOL.
  - fan_on is forced 0 in FLAME.
- Not defined: fan_on = heat_on | cool_on, and FAN_OVR_S is unused.

## Structure
- Package hvac_pkg holds:
  - the state enum and its 3-bit codes
  - the flame-clear constant (5)
  - the sec_cnt width
- Sub-module sec_tick (parameter TICK_DIV) is the 1 s prescaler and its single tick output is shared by all timers.
- The flame synchronizer is local 2-flop logic.

## Test plan
All scenarios use TICK_DIV=10, HYST=1, MIN_ON_S=3, MIN_OFF_S=4, STALE_S=10.
- Heat cycle: set 22, valid sample 19 → HEAT two cycles later. Sample 22 at tick 1 → stay HEAT until sec_cnt=3, then REST for 4 ticks, then OFF.
- Deadband: set 22, samples 21/22/23 → stays OFF. Sample 24 → COOL. Sample 22 after MIN_ON → REST.
- Invalid/stale: sample 0 or 150 → temp_r unchanged, no state change. No valid sample for 10 ticks while in HEAT → REST with fault_stale=1, and no HEAT re-entry until a new valid sample arrives.
- Flame: assert flame_in in COOL → all relays 0 after 3 cycles and state_code=4. Toggle flame → lock extended. 5 clean ticks → REST.
- Fan macro: with HVAC_FAN_OVERRUN_EN and FAN_OVR_S=2, HEAT→REST keeps fan_on=1 for 2 ticks. Without the macro, fan_on drops with heat_on.
- Reset mid-HEAT: assert reset → heat_on=0 next edge and state_code=0. A fresh sample of 19 re-enters HEAT without a REST delay.

Source files
------------

// File: rtl/hvac_pkg.sv
// Shared types and constants for the HVAC actuator stage.
package hvac_pkg;

    // Controller states; the encoding is the externally visible state_code.
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_HEAT  = 3'd1,
        ST_COOL  = 3'd2,
        ST_REST  = 3'd3,
        ST_FLAME = 3'd4
    } state_e;

    // Consecutive flame-free ticks required to leave the flame lockout.
    localparam int unsigned FLAME_CLR_TICKS = 5;

    // Width of the per-state seconds counter and the staleness counter.
    localparam int unsigned SEC_CNT_W = 16;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: emits a single-cycle tick every TICK_DIV clocks.
module sec_tick #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick_c
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap the prescaler on the terminal count, which is also the tick.
    always_comb begin
        tick_c = (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hvac_controller.sv
// HVAC actuator stage: hysteresis heat/cool decision, minimum run/rest
// timing, sensor staleness and flame lockout with registered relay outputs.
// Optional build macro HVAC_FAN_OVERRUN_EN keeps the fan running for
// FAN_OVR_S seconds in REST after a heat/cool run.
module hvac_controller
    import hvac_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned HYST      = 1,
    parameter int unsigned MIN_ON_S  = 60,
    parameter int unsigned MIN_OFF_S = 120,
    parameter int unsigned STALE_S   = 10,
    parameter int unsigned FAN_OVR_S = 30
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cur_temp,
    input  logic       cur_valid,
    input  logic [7:0] set_temp,
    input  logic       flame_in,
    output logic       heat_on,
    output logic       cool_on,
    output logic       fan_on,
    output logic [2:0] state_code,
    output logic       fault_stale,
    output logic       fault_flame
);
    localparam int unsigned W = SEC_CNT_W;
    localparam logic [W-1:0] SEC_MAX = '1;

    // Reject parameter values the datapath cannot represent.
    if (HYST > 9 || FAN_OVR_S > 65535 || STALE_S == 0) begin : g_bad_param
        $error("hvac_controller: parameter out of range");
    end

    logic           tick_c;
    state_e         state_q, state_d;
    logic [7:0]     temp_r_q, temp_r_d;
    logic           temp_ok_q, temp_ok_d;
    logic [W-1:0]   stale_cnt_q, stale_cnt_d;
    logic [W-1:0]   sec_cnt_q, sec_cnt_d;
    logic [2:0]     flame_cnt_q, flame_cnt_d;
    logic           flame_meta_q, flame_s_q;
    logic           heat_on_q, heat_on_d;
    logic           cool_on_q, cool_on_d;
    logic           fan_on_q, fan_on_d;
    logic [2:0]     state_code_q, state_code_d;
    logic           fault_stale_q, fault_stale_d;
    logic           fault_flame_q, fault_flame_d;
    logic           sample_ok_c;
    logic [8:0]     temp9_c, set9_c;
    logic           heat_start_c, cool_start_c, heat_stop_c, cool_stop_c;
`ifdef HVAC_FAN_OVERRUN_EN
    logic           from_run_q, from_run_d;
`endif

    sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick_c   (tick_c)
    );

    // Capture in-range samples; count ticks since the last good sample.
    always_comb begin
        sample_ok_c = cur_valid && (cur_temp != 8'd0) && (cur_temp <= 8'd99);
        temp_r_d    = temp_r_q;
        temp_ok_d   = temp_ok_q;
        stale_cnt_d = stale_cnt_q;
        if (sample_ok_c) begin
            temp_r_d    = cur_temp;
            temp_ok_d   = 1'b1;
            stale_cnt_d = '0;
        end else if (tick_c && temp_ok_q) begin
            stale_cnt_d = stale_cnt_q + W'(1);
            if (32'(stale_cnt_q) + 32'd1 >= STALE_S) begin
                temp_ok_d = 1'b0;
            end
        end
    end

    // Hysteresis thresholds, widened to 9 bits so the sums cannot wrap.
    always_comb begin
        temp9_c      = {1'b0, temp_r_q};
        set9_c       = {1'b0, set_temp};
        heat_start_c = (temp9_c + 9'(HYST)) < set9_c;
        cool_start_c = temp9_c > (set9_c + 9'(HYST));
        heat_stop_c  = temp9_c >= set9_c;
        cool_stop_c  = temp9_c <= set9_c;
    end

    // Next state, per-state timers and registered output values.
    always_comb begin
        state_d     = state_q;
        flame_cnt_d = flame_cnt_q;
        sec_cnt_d   = sec_cnt_q;

        if (flame_s_q) begin
            state_d = ST_FLAME;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (temp_ok_q && heat_start_c) begin
                        state_d = ST_HEAT;
                    end else if (temp_ok_q && cool_start_c) begin
                        state_d = ST_COOL;
                    end
                end
                ST_HEAT: begin
                    if (!temp_ok_q || (heat_stop_c && sec_cnt_q >= W'(MIN_ON_S))) begin
                        state_d = ST_REST;
                    end
                end
                ST_COOL: begin
                    if (!temp_ok_q || (cool_stop_c && sec_cnt_q >= W'(MIN_ON_S))) begin
                        state_d = ST_REST;
                    end
                end
                ST_REST: begin
                    if (sec_cnt_q >= W'(MIN_OFF_S)) begin
                        state_d = ST_OFF;
                    end
                end
                ST_FLAME: begin
                    if (flame_cnt_q >= 3'(FLAME_CLR_TICKS)) begin
                        state_d = ST_REST;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        // Flame-clear count restarts on any flame sample.
        if (state_q != ST_FLAME || flame_s_q) begin
            flame_cnt_d = '0;
        end else if (tick_c && flame_cnt_q < 3'(FLAME_CLR_TICKS)) begin
            flame_cnt_d = flame_cnt_q + 3'd1;
        end

        if (state_d != state_q) begin
            sec_cnt_d = '0;
        end else if (tick_c && sec_cnt_q != SEC_MAX) begin
            sec_cnt_d = sec_cnt_q + W'(1);
        end

        heat_on_d     = (state_d == ST_HEAT);
        cool_on_d     = (state_d == ST_COOL);
        fault_flame_d = (state_d == ST_FLAME);
        fault_stale_d = !temp_ok_d;
        state_code_d  = 3'(state_d);
`ifdef HVAC_FAN_OVERRUN_EN
        from_run_d = from_run_q;
        if (state_d != state_q) begin
            from_run_d = (state_d == ST_REST) &&
                         (state_q == ST_HEAT || state_q == ST_COOL);
        end
        fan_on_d = heat_on_d || cool_on_d ||
                   (state_d == ST_REST && from_run_d && sec_cnt_d < W'(FAN_OVR_S));
`else
        fan_on_d = heat_on_d || cool_on_d;
`endif
    end

    // State, datapath, flame synchronizer and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= ST_OFF;
            temp_r_q      <= '0;
            temp_ok_q     <= 1'b0;
            stale_cnt_q   <= '0;
            sec_cnt_q     <= '0;
            flame_cnt_q   <= '0;
            flame_meta_q  <= 1'b0;
            flame_s_q     <= 1'b0;
            heat_on_q     <= 1'b0;
            cool_on_q     <= 1'b0;
            fan_on_q      <= 1'b0;
            state_code_q  <= '0;
            fault_stale_q <= 1'b0;
            fault_flame_q <= 1'b0;
`ifdef HVAC_FAN_OVERRUN_EN
            from_run_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            temp_r_q      <= temp_r_d;
            temp_ok_q     <= temp_ok_d;
            stale_cnt_q   <= stale_cnt_d;
            sec_cnt_q     <= sec_cnt_d;
            flame_cnt_q   <= flame_cnt_d;
            flame_meta_q  <= flame_in;
            flame_s_q     <= flame_meta_q;
            heat_on_q     <= heat_on_d;
            cool_on_q     <= cool_on_d;
            fan_on_q      <= fan_on_d;
            state_code_q  <= state_code_d;
            fault_stale_q <= fault_stale_d;
            fault_flame_q <= fault_flame_d;
`ifdef HVAC_FAN_OVERRUN_EN
            from_run_q    <= from_run_d;
`endif
        end
    end

    assign heat_on     = heat_on_q;
    assign cool_on     = cool_on_q;
    assign fan_on      = fan_on_q;
    assign state_code  = state_code_q;
    assign fault_stale = fault_stale_q;
    assign fault_flame = fault_flame_q;

endmodule

// File: tb/tb_hvac_controller.sv
// Self-checking bench for hvac_controller with a fast 10-cycle tick.
// Output vector layout: {state_code, heat_on, cool_on, fan_on, fault_stale, fault_flame}.
module tb_hvac_controller;
    localparam int unsigned TICK_DIV  = 10;
    localparam int unsigned HYST      = 1;
    localparam int unsigned MIN_ON_S  = 3;
    localparam int unsigned MIN_OFF_S = 4;
    localparam int unsigned STALE_S   = 10;
    localparam int unsigned FAN_OVR_S = 2;
`ifdef HVAC_FAN_OVERRUN_EN
    localparam logic FAN_OVR = 1'b1;
`else
    localparam logic FAN_OVR = 1'b0;
`endif

    localparam logic [7:0] V_OFF            = {3'd0, 5'b00000};
    localparam logic [7:0] V_OFF_STALE      = {3'd0, 5'b00010};
    localparam logic [7:0] V_HEAT           = {3'd1, 5'b10100};
    localparam logic [7:0] V_COOL           = {3'd2, 5'b01100};
    localparam logic [7:0] V_REST_RUN       = {3'd3, 1'b0, 1'b0, FAN_OVR, 1'b0, 1'b0};
    localparam logic [7:0] V_REST_RUN_STALE = {3'd3, 1'b0, 1'b0, FAN_OVR, 1'b1, 1'b0};
    localparam logic [7:0] V_REST           = {3'd3, 5'b00000};
    localparam logic [7:0] V_FLAME          = {3'd4, 5'b00001};

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] cur_temp;
    logic       cur_valid;
    logic [7:0] set_temp;
    logic       flame_in;
    logic       heat_on, cool_on, fan_on, fault_stale, fault_flame;
    logic [2:0] state_code;
    logic [7:0] obs;

    int          checks = 0;
    int          errors = 0;
    int unsigned cycle  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp;

    hvac_controller #(
        .TICK_DIV  (TICK_DIV),
        .HYST      (HYST),
        .MIN_ON_S  (MIN_ON_S),
        .MIN_OFF_S (MIN_OFF_S),
        .STALE_S   (STALE_S),
        .FAN_OVR_S (FAN_OVR_S)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .cur_temp    (cur_temp),
        .cur_valid   (cur_valid),
        .set_temp    (set_temp),
        .flame_in    (flame_in),
        .heat_on     (heat_on),
        .cool_on     (cool_on),
        .fan_on      (fan_on),
        .state_code  (state_code),
        .fault_stale (fault_stale),
        .fault_flame (fault_flame)
    );

    assign obs = {state_code, heat_on, cool_on, fan_on, fault_stale, fault_flame};

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cycle <= cycle + 1;

    // One-cycle capture strobe driven from a falling edge.
    task automatic send_sample(input logic [7:0] t);
        cur_temp  = t;
        cur_valid = 1'b1;
        @(negedge CLOCK_50);
        cur_valid = 1'b0;
    endtask

    // Bounded poll for a given state code.
    task automatic wait_code(input logic [2:0] code, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLOCK_50);
            if (state_code === code) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cur_valid = 1'b0; cur_temp = 8'd0; set_temp = 8'd22; flame_in = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        exp_q.push_back(V_OFF);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, exp); end
        reset = 1'b0;
        exp_q.push_back(V_OFF_STALE);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_release: got %b expected %b", obs, exp); end
    endtask

    task automatic test_heat_cycle();
        int unsigned t0;
        int unsigned dt;
        bit ok;
        exp_q.push_back(V_OFF);
        send_sample(8'd19);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL heat_latency: got %b expected %b", obs, exp); end
        exp_q.push_back(V_HEAT);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL heat_entry: got %b expected %b", obs, exp); end
        t0 = cycle;
        send_sample(8'd22);
        wait_code(3'd3, 60, ok);
        dt = cycle - t0; checks++;
        if (!ok || dt < 22 || dt > 31) begin errors++; $display("FAIL heat_min_on: cycles %0d found %0b expected 22..31", dt, ok); end
        exp_q.push_back(V_REST_RUN);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL heat_rest: got %b expected %b", obs, exp); end
        t0 = cycle;
`ifdef HVAC_FAN_OVERRUN_EN
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CLOCK_50);
            if (fan_on === 1'b0) ok = 1'b1;
        end
        dt = cycle - t0; checks++;
        if (!ok || dt < 11 || dt > 20) begin errors++; $display("FAIL fan_overrun: cycles %0d found %0b expected 11..20", dt, ok); end
`endif
        wait_code(3'd0, 60, ok);
        dt = cycle - t0; checks++;
        if (!ok || dt < 32 || dt > 41) begin errors++; $display("FAIL rest_min_off: cycles %0d found %0b expected 32..41", dt, ok); end
        exp_q.push_back(V_OFF);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL rest_to_off: got %b expected %b", obs, exp); end
    endtask

    task automatic test_deadband();
        logic [7:0] db[3];
        int unsigned t0;
        int unsigned dt;
        bit ok;
        db[0] = 8'd21; db[1] = 8'd22; db[2] = 8'd23;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(V_OFF);
            send_sample(db[i]);
            repeat (2) @(negedge CLOCK_50);
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL deadband_%0d: got %b expected %b", db[i], obs, exp); end
        end
        exp_q.push_back(V_COOL);
        send_sample(8'd24);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL cool_entry: got %b expected %b", obs, exp); end
        t0 = cycle;
        send_sample(8'd22);
        wait_code(3'd3, 60, ok);
        dt = cycle - t0; checks++;
        if (!ok || dt < 22 || dt > 31) begin errors++; $display("FAIL cool_min_on: cycles %0d found %0b expected 22..31", dt, ok); end
        exp_q.push_back(V_REST_RUN);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL cool_rest: got %b expected %b", obs, exp); end
        wait_code(3'd0, 60, ok); checks++;
        if (!ok) begin errors++; $display("FAIL cool_rest_to_off: state %0d expected 0", state_code); end
    endtask

    task automatic test_invalid_stale();
        logic [7:0] bad[2];
        int unsigned t0;
        int unsigned dt;
        bit ok;
        bad[0] = 8'd0; bad[1] = 8'd150;
        send_sample(8'd22);
        repeat (2) @(negedge CLOCK_50);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(V_OFF);
            send_sample(bad[i]);
            repeat (3) @(negedge CLOCK_50);
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL invalid_%0d_ignored: got %b expected %b", bad[i], obs, exp); end
        end
        exp_q.push_back(V_HEAT);
        send_sample(8'd19);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL stale_heat_entry: got %b expected %b", obs, exp); end
        t0 = cycle;
        send_sample(8'd0);
        send_sample(8'd150);
        wait_code(3'd3, 120, ok);
        dt = cycle - t0; checks++;
        if (!ok || dt < 91 || dt > 100) begin errors++; $display("FAIL stale_timeout: cycles %0d found %0b expected 91..100", dt, ok); end
        exp_q.push_back(V_REST_RUN_STALE);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL stale_rest: got %b expected %b", obs, exp); end
        wait_code(3'd0, 60, ok); checks++;
        if (!ok) begin errors++; $display("FAIL stale_rest_to_off: state %0d expected 0", state_code); end
        exp_q.push_back(V_OFF_STALE);
        repeat (20) @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL stale_no_reentry: got %b expected %b", obs, exp); end
        exp_q.push_back(V_HEAT);
        send_sample(8'd19);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL stale_recover: got %b expected %b", obs, exp); end
    endtask

    task automatic test_flame();
        int unsigned t0;
        int unsigned dt;
        bit ok;
        send_sample(8'd22);
        wait_code(3'd3, 60, ok); checks++;
        if (!ok) begin errors++; $display("FAIL flame_prep_rest: state %0d expected 3", state_code); end
        wait_code(3'd0, 60, ok); checks++;
        if (!ok) begin errors++; $display("FAIL flame_prep_off: state %0d expected 0", state_code); end
        exp_q.push_back(V_COOL);
        send_sample(8'd30);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flame_cool: got %b expected %b", obs, exp); end
        flame_in = 1'b1;
        exp_q.push_back(V_COOL);
        repeat (2) @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flame_sync_delay: got %b expected %b", obs, exp); end
        exp_q.push_back(V_FLAME);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flame_lock: got %b expected %b", obs, exp); end
        repeat (20) @(negedge CLOCK_50);
        flame_in = 1'b0;
        exp_q.push_back(V_FLAME);
        repeat (25) @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flame_partial_clear: got %b expected %b", obs, exp); end
        flame_in = 1'b1;
        exp_q.push_back(V_FLAME);
        repeat (5) @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flame_retrigger: got %b expected %b", obs, exp); end
        send_sample(8'd22);
        flame_in = 1'b0;
        t0 = cycle;
        wait_code(3'd3, 80, ok);
        dt = cycle - t0; checks++;
        if (!ok || dt < 44 || dt > 53) begin errors++; $display("FAIL flame_clear_time: cycles %0d found %0b expected 44..53", dt, ok); end
        exp_q.push_back(V_REST);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flame_rest: got %b expected %b", obs, exp); end
        wait_code(3'd0, 60, ok); checks++;
        if (!ok) begin errors++; $display("FAIL flame_rest_to_off: state %0d expected 0", state_code); end
    endtask

    task automatic test_back_to_back();
        int unsigned t0;
        int unsigned dt;
        bit ok;
        exp_q.push_back(V_HEAT);
        send_sample(8'd19);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL sp_heat_entry: got %b expected %b", obs, exp); end
        t0 = cycle;
        repeat (5) @(negedge CLOCK_50);
        set_temp = 8'd15;
        wait_code(3'd3, 60, ok);
        dt = cycle - t0; checks++;
        if (!ok || dt < 22 || dt > 31) begin errors++; $display("FAIL sp_change_min_on: cycles %0d found %0b expected 22..31", dt, ok); end
        exp_q.push_back(V_REST_RUN);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL sp_rest: got %b expected %b", obs, exp); end
        set_temp = 8'd22;
        wait_code(3'd0, 60, ok); checks++;
        if (!ok) begin errors++; $display("FAIL sp_rest_to_off: state %0d expected 0", state_code); end
        wait_code(3'd1, 2, ok); checks++;
        if (!ok) begin errors++; $display("FAIL back_to_back_heat: state %0d expected 1", state_code); end
    endtask

    task automatic test_reset_mid_heat();
        reset = 1'b1;
        exp_q.push_back(V_OFF);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_drop: got %b expected %b", obs, exp); end
        reset = 1'b0;
        exp_q.push_back(V_OFF_STALE);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_release: got %b expected %b", obs, exp); end
        exp_q.push_back(V_OFF);
        send_sample(8'd19);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_sample_latency: got %b expected %b", obs, exp); end
        exp_q.push_back(V_HEAT);
        @(negedge CLOCK_50);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_heat_no_rest: got %b expected %b", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_heat_cycle();
        test_deadband();
        test_invalid_stale();
        test_flame();
        test_back_to_back();
        test_reset_mid_heat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1);
    end

endmodule
